ps2_receiver: RTL and testbench

//  Memory-mapped PS/2 keyboard receiver; the input-direction peripheral next to lcd_controller/vga_controller.

---
 rtl/ps2_receiver_pkg.sv | 31 +++
 rtl/ps2_receiver_sync_fifo.sv | 56 +++++
 rtl/ps2_receiver.sv | 189 ++++++++++++++++++
 tb/tb_ps2_receiver.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_receiver_pkg.sv
// Shared definitions for the PS/2 receiver: register offsets, register bit
// positions, frame FSM encoding and the STATUS count display helper.
`timescale 1ns/1ps
package ps2_receiver_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;

   localparam int ST_NONEMPTY  = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_OVF       = 2;
   localparam int ST_PERR      = 3;
   localparam int ST_FERR      = 4;
   localparam int ST_COUNT_LSB = 8;
   localparam int DATA_VALID   = 8;
   localparam int CTRL_IE      = 0;

   typedef enum logic [1:0] {
      FRM_IDLE,
      FRM_DATA,
      FRM_PARITY,
      FRM_STOP
   } frame_state_e;

   // The STATUS count field is 4 bits wide; deeper FIFOs show 15.
   function automatic logic [3:0] sat_count4(input logic [31:0] cnt);
      return (cnt > 32'd15) ? 4'hF : cnt[3:0];
   endfunction

endpackage

// File: rtl/ps2_receiver_sync_fifo.sv
// Register-based FIFO with show-ahead head; a push while full is accepted
// only when a pop frees a slot in the same cycle.
`timescale 1ns/1ps
module ps2_receiver_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/ps2_receiver.sv
// Memory-mapped PS/2 device-to-host receiver: synchronise and filter the pins,
// deframe bytes, buffer them in a FIFO and raise an active-low interrupt.
`timescale 1ns/1ps
module ps2_receiver
   import ps2_receiver_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic [1:0]  addr,
   input  logic        rd_en,
   input  logic        wenable,
   input  logic [7:0]  wdata,
   output logic [31:0] rdata,
   output logic        irq_n
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int FCW   = $clog2(FILTER_LEN) + 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic filt_q, filt_d, pulse_q, pulse_d;
   logic [FCW-1:0] flt_cnt_q, flt_cnt_d;

   frame_state_e state_q;
   logic [7:0]       shift_q;
   logic [2:0]       bit_cnt_q;
   logic             par_ok_q, perr_set_q, ferr_set_q;
   logic [TMO_W-1:0] tmo_cnt_q;

   logic ie_q, ie_d, ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d, irq_n_q, irq_n_d;
   logic push, pop, wr_status, wr_ctrl;
   logic fifo_full, fifo_empty;
   logic [7:0]       fifo_head;
   logic [CNT_W-1:0] fifo_count;
   logic unused_wdata;

   assign unused_wdata = ^{wdata[7:5], wdata[1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= ps2_clk;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= ps2_data;
         dat_s2_q <= dat_s1_q;
      end
   end

   // The filtered clock only flips after FILTER_LEN consecutive opposite samples.
   always_comb begin
      filt_d    = filt_q;
      flt_cnt_d = '0;
      if (clk_s2_q != filt_q) begin
         if (flt_cnt_q == FCW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
         else flt_cnt_d = flt_cnt_q + 1'b1;
      end
      pulse_d = filt_q & ~filt_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FRM_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         par_ok_q   <= 1'b0;
         perr_set_q <= 1'b0;
         ferr_set_q <= 1'b0;
         tmo_cnt_q  <= '0;
      end else begin
         perr_set_q <= 1'b0;
         ferr_set_q <= 1'b0;
         if (state_q != FRM_IDLE && !pulse_q && tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_q    <= FRM_IDLE;
            ferr_set_q <= 1'b1;
            tmo_cnt_q  <= '0;
         end else if (pulse_q) begin
            tmo_cnt_q <= '0;
            case (state_q)
               FRM_IDLE: begin
                  if (!dat_s2_q) begin
                     state_q   <= FRM_DATA;
                     bit_cnt_q <= '0;
                  end
               end
               FRM_DATA: begin
                  shift_q   <= {dat_s2_q, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) state_q <= FRM_PARITY;
               end
               FRM_PARITY: begin
                  par_ok_q   <= ^{shift_q, dat_s2_q};
                  perr_set_q <= ~^{shift_q, dat_s2_q};
                  state_q    <= FRM_STOP;
               end
               FRM_STOP: begin
                  ferr_set_q <= ~dat_s2_q;
                  state_q    <= FRM_IDLE;
               end
               default: state_q <= FRM_IDLE;
            endcase
         end else if (state_q != FRM_IDLE) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
         end
      end
   end

   // Pushing straight from the stop-bit pulse makes the byte readable next cycle.
   always_comb begin
      push      = pulse_q & (state_q == FRM_STOP) & dat_s2_q & par_ok_q;
      pop       = rd_en & (addr == REG_DATA) & ~fifo_empty;
      wr_status = wenable & (addr == REG_STATUS);
      wr_ctrl   = wenable & (addr == REG_CTRL);
      ie_d      = wr_ctrl ? wdata[CTRL_IE] : ie_q;
      ovf_d     = (ovf_q  & ~(wr_status & wdata[ST_OVF]))  | (push & fifo_full & ~pop);
      perr_d    = (perr_q & ~(wr_status & wdata[ST_PERR])) | perr_set_q;
      ferr_d    = (ferr_q & ~(wr_status & wdata[ST_FERR])) | ferr_set_q;
      irq_n_d   = ~(ie_q & ~fifo_empty);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_q    <= 1'b1;
         flt_cnt_q <= '0;
         pulse_q   <= 1'b0;
         ie_q      <= 1'b0;
         ovf_q     <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         irq_n_q   <= 1'b1;
      end else begin
         filt_q    <= filt_d;
         flt_cnt_q <= flt_cnt_d;
         pulse_q   <= pulse_d;
         ie_q      <= ie_d;
         ovf_q     <= ovf_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         irq_n_q   <= irq_n_d;
      end
   end

   assign irq_n = irq_n_q;

   ps2_receiver_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (shift_q),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      rdata = '0;
      case (addr)
         REG_DATA: begin
            if (!fifo_empty) begin
               rdata[7:0]        = fifo_head;
               rdata[DATA_VALID] = 1'b1;
            end
         end
         REG_STATUS: begin
            rdata[ST_NONEMPTY] = ~fifo_empty;
            rdata[ST_FULL]     = fifo_full;
            rdata[ST_OVF]      = ovf_q;
            rdata[ST_PERR]     = perr_q;
            rdata[ST_FERR]     = ferr_q;
            rdata[ST_COUNT_LSB +: 4] = sat_count4(32'(fifo_count));
         end
         REG_CTRL: rdata[CTRL_IE] = ie_q;
         default:  rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: frames driven on the PS/2 pins, DATA reads
// checked by a scoreboard monitor, STATUS/CTRL/irq_n checked inline.
`timescale 1ns/1ps
module tb_ps2_receiver;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 200;
   localparam int HALF    = 20;
   localparam int GAP     = 30;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [1:0]  addr = 2'd3;
   logic        rd_en = 1'b0;
   logic        wenable = 1'b0;
   logic [7:0]  wdata = 8'h00;
   logic [31:0] rdata;
   logic        irq_n;

   logic [7:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   ps2_receiver #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .addr     (addr),
      .rd_en    (rd_en),
      .wenable  (wenable),
      .wdata    (wdata),
      .rdata    (rdata),
      .irq_n    (irq_n)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
      end
   endtask

   // scoreboard monitor: every DATA read is compared against the expected queue
   always @(negedge clk) begin
      if (rd_en && addr == 2'd0) begin
         if (exp_q.size() > 0) check("data_read", rdata, {23'd0, 1'b1, exp_q.pop_front()});
         else check("data_read_empty", rdata, 32'd0);
      end
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ps2_bit(input logic b, input bit pop_at_fall);
      ps2_data = b;
      tick(HALF);
      ps2_clk = 1'b0;
      if (pop_at_fall) begin
         // lands the read strobe on the cycle the stop bit pushes
         tick(6);
         addr  = 2'd0;
         rd_en = 1'b1;
         tick(1);
         rd_en = 1'b0;
         tick(HALF - 7);
      end else begin
         tick(HALF);
      end
      ps2_clk = 1'b1;
   endtask

   task automatic glitch();
      tick(5);
      ps2_clk = 1'b0;
      tick(2);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch_mid,
                             input bit pop_at_stop);
      logic par;
      par = ~^b ^ bad_par;
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         ps2_bit(b[i], 1'b0);
         if (glitch_mid && i == 3) glitch();
      end
      ps2_bit(par, 1'b0);
      ps2_bit(1'b1, pop_at_stop);
      tick(GAP);
   endtask

   task automatic send_good(input logic [7:0] b, input bit glitch_mid, input bit pop_at_stop);
      send_frame(b, 1'b0, glitch_mid, pop_at_stop);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
   endtask

   task automatic read_data();
      addr  = 2'd0;
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      addr  = 2'd3;
      tick(1);
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
      addr = a;
      @(negedge clk);
      v = rdata;
      @(posedge clk);
      #1;
      addr = 2'd3;
   endtask

   task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
      addr    = a;
      wdata   = d;
      wenable = 1'b1;
      tick(1);
      wenable = 1'b0;
      addr    = 2'd3;
   endtask

   task automatic check_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] v;
      read_reg(a, v);
      check(name, v, exp);
   endtask

   task automatic check_irq(input string name, input logic exp);
      @(negedge clk);
      check(name, {31'd0, irq_n}, {31'd0, exp});
      tick(1);
   endtask

   initial begin
      tick(3);
      rst_n = 1'b1;
      tick(3);

      // reset state
      check_reg("reset_status", 2'd1, 32'h0);
      check_reg("reset_ctrl", 2'd2, 32'h0);
      check_irq("reset_irq_n", 1'b1);
      read_data();
      check_reg("reserved_reads_0", 2'd3, 32'h0);

      // single good frame with interrupt enabled
      write_reg(2'd2, 8'h01);
      check_reg("ctrl_ie", 2'd2, 32'h1);
      send_good(8'h1C, 1'b0, 1'b0);
      check_irq("irq_after_frame", 1'b0);
      check_reg("status_one", 2'd1, 32'h101);
      read_data();
      tick(1);
      check_irq("irq_after_pop", 1'b1);
      check_reg("status_empty", 2'd1, 32'h0);

      // wrong parity bit for 0xF0 (correct odd parity would be 1)
      send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
      check_reg("status_perr", 2'd1, 32'h08);
      check_irq("irq_perr_idle", 1'b1);
      write_reg(2'd1, 8'h08);
      check_reg("perr_w1c", 2'd1, 32'h0);

      // overflow: DEPTH+1 frames with no reads
      for (int i = 1; i <= DEPTH + 1; i++) send_good(8'(i), 1'b0, 1'b0);
      check_reg("status_full_ovf", 2'd1, 32'h807);
      check_irq("irq_full", 1'b0);
      for (int i = 0; i <= DEPTH; i++) read_data();
      write_reg(2'd1, 8'h04);
      check_reg("ovf_w1c", 2'd1, 32'h0);

      // timeout mid-frame, then a clean frame
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
      tick(TIMEOUT + 20);
      check_reg("status_ferr", 2'd1, 32'h10);
      write_reg(2'd1, 8'h10);
      send_good(8'h5A, 1'b0, 1'b0);
      check_reg("after_timeout", 2'd1, 32'h101);
      read_data();

      // glitches in idle and mid-frame must not be sampled
      ps2_data = 1'b0;
      glitch();
      tick(HALF);
      ps2_data = 1'b1;
      tick(HALF);
      send_good(8'h33, 1'b1, 1'b0);
      check_reg("glitch_status", 2'd1, 32'h101);
      read_data();

      // reset mid-frame discards the partial frame
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(5);
      check_reg("ctrl_after_reset", 2'd2, 32'h0);
      send_good(8'h29, 1'b0, 1'b0);
      check_reg("status_after_reset", 2'd1, 32'h101);
      check_irq("irq_ie_off", 1'b1);
      read_data();

      // pop coinciding with a push while full
      for (int i = 0; i < DEPTH; i++) send_good(8'h40 + 8'(i), 1'b0, 1'b0);
      check_reg("full_before_collide", 2'd1, 32'h803);
      send_good(8'h48, 1'b0, 1'b1);
      check_reg("full_after_collide", 2'd1, 32'h803);
      for (int i = 0; i < DEPTH; i++) read_data();
      check_reg("final_empty", 2'd1, 32'h0);
      check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
